fsm_qos_param: RTL

Parametrised successor to the QoS control state machine of the PCIe traffic-class/virtual-channel datapath. Supervises NUM_FIFOS FIFOs (main FIFO, VC FIFOs, destination FIFOs) through RESET/INIT/IDLE/ACTIVE/ERROR states. Captures a per-FIFO almost-full/almost-empty threshold of UMB_W bits during INIT and holds it for the FIFO bank. Additions over the previous generation:
- error-source identification
- sticky error recovery via init
- saturating error-event counter
- ACTIVE->IDLE hysteresis

---
 rtl/fsm_qos_pkg.sv | 21 ++
 rtl/fsm_qos_param_if.sv | 20 ++
 rtl/prio_enc_lsb.sv | 18 +
 rtl/fsm_qos_param.sv | 106 ++++++++++
 4 files changed

// File: rtl/fsm_qos_pkg.sv
// rtl/fsm_qos_pkg.sv - state encodings and helpers for the QoS supervisor FSM
package fsm_qos_pkg;

   localparam int ST_W = 3;

   typedef enum logic [ST_W-1:0] {
      ST_RESET  = 3'd0,
      ST_INIT   = 3'd1,
      ST_IDLE   = 3'd2,
      ST_ACTIVE = 3'd3,
      ST_ERROR  = 3'd4
   } state_e;

   // Counter of width w stops at its all-ones value instead of wrapping.
   function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
      logic [31:0] max_v;
      max_v = (32'd1 << w) - 32'd1;
      return (v >= max_v) ? max_v : v + 32'd1;
   endfunction

endpackage

// File: rtl/fsm_qos_param_if.sv
// rtl/fsm_qos_param_if.sv - FIFO bank status/threshold bundle between bank and supervisor
interface fsm_qos_param_if #(
   parameter int NUM_FIFOS = 5,
   parameter int UMB_W     = 2
);
   logic [NUM_FIFOS*UMB_W-1:0] umbrales_in;
   logic [NUM_FIFOS-1:0]       FIFO_EMPTIES;
   logic [NUM_FIFOS-1:0]       FIFO_ERRORS;
   logic [NUM_FIFOS*UMB_W-1:0] umbrales_out;

   modport master (
      output umbrales_in, FIFO_EMPTIES, FIFO_ERRORS,
      input  umbrales_out
   );

   modport slave (
      input  umbrales_in, FIFO_EMPTIES, FIFO_ERRORS,
      output umbrales_out
   );
endinterface

// File: rtl/prio_enc_lsb.sv
// rtl/prio_enc_lsb.sv - index of the lowest set bit with a valid flag
module prio_enc_lsb #(
   parameter int N  = 5,
   parameter int IW = 3
) (
   input  logic [N-1:0]  vec,
   output logic [IW-1:0] idx,
   output logic          valid
);
   always_comb begin
      idx   = '0;
      valid = |vec;
      // Scan high to low so the lowest set bit is the last writer.
      for (int i = N - 1; i >= 0; i--) begin
         if (vec[i]) idx = IW'(i);
      end
   end
endmodule

// File: rtl/fsm_qos_param.sv
// rtl/fsm_qos_param.sv - QoS supervisor FSM with threshold capture, error tracking and idle hysteresis
module fsm_qos_param
   import fsm_qos_pkg::*;
#(
   parameter int NUM_FIFOS = 5,
   parameter int UMB_W     = 2,
   parameter int IDLE_HOLD = 4,
   parameter int ERRCNT_W  = 4,
   parameter int IDX_W     = 3
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                init,
   fsm_qos_param_if.slave      bank,
   output logic [ST_W-1:0]     state_out,
   output logic                idle_out,
   output logic                active_out,
   output logic                error_out,
   output logic [IDX_W-1:0]    error_fifo,
   output logic [ERRCNT_W-1:0] error_count
);
   localparam int HOLD_W = $clog2(IDLE_HOLD + 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(IDLE_HOLD - 1);

   state_e                     state_q, state_d;
   logic [HOLD_W-1:0]          hold_q, hold_d;
   logic [NUM_FIFOS*UMB_W-1:0] umb_q, umb_d;
   logic [IDX_W-1:0]           err_fifo_q, err_fifo_d;
   logic [ERRCNT_W-1:0]        err_cnt_q, err_cnt_d;
   logic [IDX_W-1:0]           err_idx;
   logic                       any_err;
   logic                       all_empty;
   logic                       enter_err;

   prio_enc_lsb #(.N(NUM_FIFOS), .IW(IDX_W)) u_err_enc (
      .vec   (bank.FIFO_ERRORS),
      .idx   (err_idx),
      .valid (any_err)
   );

   assign all_empty = &bank.FIFO_EMPTIES;

   always_comb begin
      state_d    = state_q;
      hold_d     = '0;
      umb_d      = umb_q;
      err_fifo_d = err_fifo_q;
      err_cnt_d  = err_cnt_q;
      enter_err  = 1'b0;
      case (state_q)
         ST_RESET: state_d = ST_INIT;
         ST_INIT: begin
            umb_d = bank.umbrales_in;
            if (any_err)   enter_err = 1'b1;
            else if (!init) state_d = ST_IDLE;
         end
         ST_IDLE: begin
            if (any_err)         enter_err = 1'b1;
            else if (init)       state_d = ST_INIT;
            else if (!all_empty) state_d = ST_ACTIVE;
         end
         ST_ACTIVE: begin
            if (any_err)      enter_err = 1'b1;
            else if (init)    state_d = ST_INIT;
            else if (all_empty) begin
               if (hold_q == HOLD_LAST) state_d = ST_IDLE;
               else                     hold_d  = hold_q + 1'b1;
            end
         end
         ST_ERROR: begin
            // Sticky: only a clean init releases it; source index stays frozen.
            if (init && !any_err) state_d = ST_INIT;
         end
         default: state_d = ST_RESET;
      endcase
      if (enter_err) begin
         state_d    = ST_ERROR;
         err_fifo_d = err_idx;
         err_cnt_d  = ERRCNT_W'(sat_inc(32'(err_cnt_q), ERRCNT_W));
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= ST_RESET;
         hold_q     <= '0;
         umb_q      <= '0;
         err_fifo_q <= '0;
         err_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         hold_q     <= hold_d;
         umb_q      <= umb_d;
         err_fifo_q <= err_fifo_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   assign state_out         = state_q;
   assign idle_out          = (state_q == ST_IDLE);
   assign active_out        = (state_q == ST_ACTIVE);
   assign error_out         = (state_q == ST_ERROR);
   assign error_fifo        = err_fifo_q;
   assign error_count       = err_cnt_q;
   assign bank.umbrales_out = umb_q;
endmodule
